uart_rx_fifo: RTL and testbench

- UART receive front end of the serial debug unit.
- Converts the rxd serial line into bytes and presents them on the vld_rx/rdy_rx/d_rx handshake consumed by the debug command processor.
- Clocked by the 16x-baud divided clock (16 ticks per bit at 9600 baud).
- Performs input synchronisation, start-bit validation and mid-bit sampling, and buffers received bytes in a small FIFO so command parsing stalls do not lose characters.

---
 rtl/sdu_pkg.sv | 22 ++
 rtl/uart_rx_fifo_if.sv | 12 +
 rtl/sdu_byte_fifo.sv | 65 ++++++
 rtl/uart_rx_fifo.sv | 147 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdu_pkg.sv
// Shared serial-debug-unit definitions: receiver state encoding, frame defaults
// and the baud divider constant used by the 16x clock generator.
package sdu_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DATA_BITS_DEF  = 8;
  // 50 MHz system clock / (16 * 9600 baud), rounded to nearest.
  localparam int unsigned BAUD_DIV       = 326;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte handshake between the UART receiver (master) and the command processor
// (slave).
interface uart_rx_fifo_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] d_rx;
  logic                 vld_rx;
  logic                 rdy_rx;

  modport master (output d_rx, output vld_rx, input rdy_rx);
  modport slave  (input d_rx, input vld_rx, output rdy_rx);
endinterface

// File: rtl/sdu_byte_fifo.sv
// Synchronous FIFO with a registered head word; pointers carry an extra wrap bit
// so full and empty are distinguishable. Push while full is accepted only with a pop.
module sdu_byte_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(Depth):0]   level_o
);
  localparam int unsigned AW = $clog2(Depth);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [Width-1:0] head_q, head_d;
  logic             empty, do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full_o  = (wr_q == (rd_q ^ {1'b1, {AW{1'b0}}}));
  assign do_pop  = pop_i & ~empty;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = data_i;
      wr_d                = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
    // Head register tracks the post-update read slot, including a same-cycle push.
    head_d = mem_d[rd_d[AW-1:0]];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q   <= '0;
      rd_q   <= '0;
      head_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      head_q <= head_d;
      mem_q  <= mem_d;
    end
  end

  assign data_o  = head_q;
  assign valid_o = ~empty;
  assign level_o = wr_q - rd_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with start validation, mid-bit sampling and a byte FIFO.
// Define RX_MAJORITY_EN to sample with a 3-tick majority vote instead of raw rxs.
module uart_rx_fifo
  import sdu_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          rxd,
  uart_rx_fifo_if.master                rx_if,
  output logic                          ferr,
  output logic                          ovr,
  input  logic                          clr_err,
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_BITS);
  localparam logic [TickW-1:0] HalfTick = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] LastTick = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  LastBit  = BitW'(DATA_BITS - 1);

  logic [1:0]           sync_q, sync_d;
  logic                 rxs, sample;
  rx_state_t            state_q, state_d;
  logic [TickW-1:0]     tick_q, tick_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 ferr_q, ferr_d, ovr_q, ovr_d;
  logic                 push, pop, fifo_full;

  assign sync_d = {sync_q[0], rxd};
  assign rxs    = sync_q[1];

`ifdef RX_MAJORITY_EN
  logic [1:0] hist_q, hist_d;
  assign hist_d = {hist_q[0], rxs};
  assign sample = maj3(rxs, hist_q[0], hist_q[1]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) hist_q <= 2'b11;
    else       hist_q <= hist_d;
  end
`else
  assign sample = rxs;
`endif

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    push    = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          tick_d  = '0;
        end
      end
      START: begin
        if (tick_q == HalfTick) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = sample ? IDLE : DATA;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      DATA: begin
        if (tick_q == LastTick) begin
          tick_d  = '0;
          shift_d = {sample, shift_q[DATA_BITS-1:1]};
          if (bit_q == LastBit) state_d = STOP;
          else                  bit_d   = bit_q + 1'b1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      STOP: begin
        if (tick_q == LastTick) begin
          tick_d = '0;
          // Leave on the mid-stop sample so the next start edge is not missed.
          if (sample) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      BREAK: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop   = rx_if.vld_rx & rx_if.rdy_rx;
  // A new overrun outranks a same-cycle clear.
  assign ovr_d = (push & fifo_full & ~pop) | (ovr_q & ~clr_err);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  sdu_byte_fifo #(
    .Width (DATA_BITS),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rstn),
    .push_i  (push),
    .data_i  (shift_q),
    .pop_i   (pop),
    .data_o  (rx_if.d_rx),
    .valid_o (rx_if.vld_rx),
    .full_o  (fifo_full),
    .level_o (level)
  );

  assign ferr = ferr_q;
  assign ovr  = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: builds a per-cycle line waveform, decodes it with a
// frame-level reference receiver and checks every output against a queue FIFO model.
module tb_uart_rx_fifo;
  localparam int OS = 16;
  localparam int DB = 8;
  localparam int FD = 4;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          rxd = 1'b1;
  logic          clr_err = 1'b0;
  logic          ferr, ovr;
  logic [LW-1:0] level;

  uart_rx_fifo_if #(.DATA_BITS(DB)) rx_if ();

  uart_rx_fifo #(
    .OVERSAMPLE (OS),
    .DATA_BITS  (DB),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .rxd     (rxd),
    .rx_if   (rx_if),
    .ferr    (ferr),
    .ovr     (ovr),
    .clr_err (clr_err),
    .level   (level)
  );

  always #5 clk = ~clk;

  // Per-cycle stimulus; index k is driven on the negedge before posedge k.
  bit w_rxd[$], w_rdy[$], w_clr[$], w_rst[$];
  bit cur_rdy = 1'b0;
  bit rnd_mode = 1'b0;
  int lit_idx[$], lit_kind[$], lit_val[$];

  bit         ev_push[];
  bit         ev_ferr[];
  logic [7:0] ev_byte[];
  int         n;
  int         nchk = 0;
  int         nerr = 0;
  int         cur = 0;

  task automatic put(input bit r, input int cnt);
    repeat (cnt) begin
      w_rxd.push_back(r);
      w_rdy.push_back(rnd_mode ? ($urandom_range(0, 3) != 0) : cur_rdy);
      w_clr.push_back(rnd_mode ? ($urandom_range(0, 40) == 0) : 1'b0);
      w_rst.push_back(1'b1);
    end
  endtask

  task automatic put_rst(input int cnt);
    repeat (cnt) begin
      w_rxd.push_back(1'b1);
      w_rdy.push_back(cur_rdy);
      w_clr.push_back(1'b0);
      w_rst.push_back(1'b0);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit stop, output int f);
    f = w_rxd.size();
    put(1'b0, OS);
    for (int i = 0; i < DB; i++) put(b[i], OS);
    put(stop, OS);
  endtask

  task automatic lit(input int idx, input int kind, input int val);
    lit_idx.push_back(idx);
    lit_kind.push_back(kind);
    lit_val.push_back(val);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cur, act, exp);
    end
  endtask

  function automatic int first_rst(input int a, input int b);
    for (int j = a; j <= b; j++) begin
      if (j < n && !w_rst[j]) return j;
    end
    return -1;
  endfunction

  // Frame-level receiver: a line low seen at index f is checked at f+8, data bit i
  // is sampled at f+24+16i, the stop bit at f+152, and the result lands at posedge f+154.
  task automatic decode();
    int k, f, r, j;
    logic [7:0] b;
    k = 0;
    while (k < n) begin
      if (!w_rst[k] || w_rxd[k]) begin
        k++;
        continue;
      end
      f = k;
      if (f + 160 > n) break;
      r = first_rst(f + 1, f + 10);
      if (r >= 0) begin k = r; continue; end
      if (w_rxd[f+8]) begin k = f + 9; continue; end
      r = first_rst(f + 11, f + 154);
      if (r >= 0) begin k = r; continue; end
      for (int i = 0; i < DB; i++) b[i] = w_rxd[f+24+16*i];
      if (w_rxd[f+152]) begin
        ev_push[f+154] = 1'b1;
        ev_byte[f+154] = b;
        k = f + 153;
      end else begin
        ev_ferr[f+154] = 1'b1;
        j = f + 153;
        while (j < n && w_rst[j] && !w_rxd[j]) j++;
        if (j < n && !w_rst[j]) k = j;
        else                    k = j + 1;
      end
    end
  endtask

  initial begin
    int f, f5, s, c, g, r;
    logic [7:0] mq[$];
    bit m_ovr, m_ferr, pop, full, set;
    logic [31:0] act;

    put_rst(4);
    put(1'b1, 20);

    // Single byte, consumer always ready.
    cur_rdy = 1'b1;
    send(8'hA5, 1'b1, f);
    lit(f + 155, 0, 1); lit(f + 155, 1, 8'hA5); lit(f + 155, 4, 0);
    lit(f + 156, 0, 0); lit(f + 157, 2, 0);
    put(1'b1, 6);

    // Short low glitch on the idle line.
    g = w_rxd.size();
    put(1'b0, 3);
    put(1'b1, 30);
    lit(g + 20, 0, 0); lit(g + 20, 2, 0);

    // Framing error, held-low break, then a clean frame.
    send(8'h3C, 1'b0, f);
    put(1'b0, 40);
    put(1'b1, 10);
    lit(f + 155, 4, 1); lit(f + 156, 4, 0); lit(f + 155, 0, 0);
    send(8'h55, 1'b1, f);
    lit(f + 155, 0, 1); lit(f + 155, 1, 8'h55);
    put(1'b1, 6);

    // Overrun with a stalled consumer, then drain and clear.
    cur_rdy = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send(8'(i), 1'b1, f5);
      put(1'b1, 4);
    end
    lit(f5 + 155, 2, 4); lit(f5 + 155, 3, 1);
    put(1'b1, 6);
    cur_rdy = 1'b1;
    s = w_rxd.size();
    put(1'b1, 10);
    lit(s, 1, 8'h01); lit(s + 1, 1, 8'h02); lit(s + 2, 1, 8'h03); lit(s + 3, 1, 8'h04);
    lit(s + 4, 0, 0);
    c = w_rxd.size();
    put(1'b1, 6);
    w_clr[c] = 1'b1;
    lit(c, 3, 1); lit(c + 1, 3, 0);

    // Full FIFO with a pop on the same cycle as the fifth push.
    cur_rdy = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send(8'(i), 1'b1, f5);
      put(1'b1, 4);
    end
    w_rdy[f5+154] = 1'b1;
    lit(f5 + 155, 2, 4); lit(f5 + 155, 3, 0); lit(f5 + 155, 1, 8'h02);
    put(1'b1, 6);
    cur_rdy = 1'b1;
    s = w_rxd.size();
    put(1'b1, 10);
    lit(s, 1, 8'h02); lit(s + 1, 1, 8'h03); lit(s + 2, 1, 8'h04); lit(s + 3, 1, 8'h05);
    lit(s + 4, 0, 0);

    // Reset in the middle of bit 4 with two bytes buffered.
    cur_rdy = 1'b0;
    send(8'h01, 1'b1, f); put(1'b1, 4);
    send(8'h02, 1'b1, f); put(1'b1, 4);
    put(1'b0, OS);
    for (int i = 0; i < 4; i++) put(1'(8'h99 >> i), OS);
    put(1'b1, 8);
    r = w_rxd.size();
    put_rst(3);
    put(1'b1, 20);
    lit(r, 2, 2); lit(r, 0, 1); lit(r + 1, 2, 0); lit(r + 1, 0, 0);
    cur_rdy = 1'b1;
    send(8'h7E, 1'b1, f);
    lit(f + 155, 0, 1); lit(f + 155, 1, 8'h7E);
    put(1'b1, 6);

    // Random frames, random consumer stalls, glitches, framing errors and clears.
    rnd_mode = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        put(1'b0, $urandom_range(1, 5));
        put(1'b1, 12);
      end
      send(8'($urandom), ($urandom_range(0, 7) != 0), f);
      put(1'b1, $urandom_range(0, 20));
    end
    rnd_mode = 1'b0;
    cur_rdy  = 1'b1;
    put(1'b1, 40);

    n = w_rxd.size();
    ev_push = new[n];
    ev_ferr = new[n];
    ev_byte = new[n];
    decode();

    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cur = k;
      chk("vld_rx", 32'(rx_if.vld_rx), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("d_rx", 32'(rx_if.d_rx), 32'(mq[0]));
      chk("level", 32'(level), 32'(mq.size()));
      chk("ovr", 32'(ovr), 32'(m_ovr));
      chk("ferr", 32'(ferr), 32'(m_ferr));
      for (int i = 0; i < lit_idx.size(); i++) begin
        if (lit_idx[i] == k) begin
          case (lit_kind[i])
            0:       act = 32'(rx_if.vld_rx);
            1:       act = 32'(rx_if.d_rx);
            2:       act = 32'(level);
            3:       act = 32'(ovr);
            default: act = 32'(ferr);
          endcase
          chk($sformatf("literal_kind%0d", lit_kind[i]), act, 32'(lit_val[i]));
        end
      end

      rxd       = w_rxd[k];
      rx_if.rdy_rx = w_rdy[k];
      clr_err   = w_clr[k];
      rstn      = w_rst[k];

      if (!w_rst[k]) begin
        mq.delete();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
      end else begin
        pop    = (mq.size() != 0) && w_rdy[k];
        full   = (mq.size() == FD);
        set    = ev_push[k] && full && !pop;
        m_ferr = ev_ferr[k];
        if (pop) void'(mq.pop_front());
        if (ev_push[k] && !set) mq.push_back(ev_byte[k]);
        if (set)           m_ovr = 1'b1;
        else if (w_clr[k]) m_ovr = 1'b0;
      end
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
